mmio_pwm_timer: RTL
===================

Name: mmio_pwm_timer

Overview:
- Memory-mapped peripheral responder on the processor's data-memory store/load interface (write_mem, funct3, write_address, write_data, read_address, read_data).
- Decodes a 256-byte window at BASE_ADDR and holds an LED register, three 8-bit RGB PWM duty registers, and free-running microsecond/millisecond counters.
- Drives led/red/green/blue pins.
- Sits beside the main memory; top level selects read_data from this block when hit_q=1.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: window base; the window is BASE_ADDR[31:8] match on address[31:8].
- CLK_PER_US, 12: clock cycles per microsecond tick (12 MHz board clock).
- US_PER_MS, 1000: microsecond ticks per millisecond tick.
- LED_ACTIVE_LOW, 1: 1 means led/red/green/blue pins are inverted (pin low = on).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- write_mem  input  1  store strobe, sampled on rising clk
- funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- write_address  input  32  store byte address
- write_data  input  32  store data, right-justified
- read_address  input  32  load byte address
- read_data  output  32  load data, registered, extended per funct3
- hit_q  output  1  registered: previous read_address was inside the window
- led  output  1  user LED pin
- red  output  1  PWM pin
- green  output  1  PWM pin
- blue  output  1  PWM pin

Behaviour:
- Register map (offset = address[7:0]):
  - 0x00 LED: bit0 is the LED, bits 31:1 read 0.
  - 0x04 DUTY_R[7:0].
  - 0x08 DUTY_G[7:0].
  - 0x0C DUTY_B[7:0].
  - 0x10 MICROS, read-only.
  - 0x14 MILLIS, read-only.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset (reset==0 at a clk edge): all registers, counters, the PWM counter, read_data and hit_q are 0. The "off" pin level is then driven: with LED_ACTIVE_LOW=1, all four pins are 1.
- Stores:
  - Take effect at the clk edge where write_mem=1 and write_address is in the window.
  - SB writes byte lane write_address[1:0].
  - SH writes the half selected by write_address[1]; writes with write_address[0]=1 are ignored.
  - SW writes the full word; writes with write_address[1:0]!=0 are ignored.
  - Only implemented bits change; other bits hold.
  - Any funct3 other than 000/001/010 on a store is ignored.
- Loads:
  - One-cycle latency: read_address and funct3 sampled at edge N; read_data and hit_q valid after edge N.
  - Lane select uses the registered read_address[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
  - Misaligned half/word loads return 0.
  - Out-of-window loads give read_data=0 and hit_q=0.
- Same-cycle store and load to the same register: the load returns the pre-store value.
- Timebase:
  - us_div counts 0..CLK_PER_US-1; on the wrap, MICROS increments and ms_div increments.
  - ms_div counts 0..US_PER_MS-1; on its wrap, MILLIS increments.
  - Both counters are 32-bit and wrap 0xFFFF_FFFF -> 0 silently.
- PWM:
  - pwm_cnt is an 8-bit free-running counter, incremented every clk and wrapping at 255->0.
  - Channel is on when pwm_cnt < DUTY. DUTY=0 means always off; DUTY=255 means on 255/256.
  - Pin = on XOR LED_ACTIVE_LOW, registered (one-cycle delay after the compare).
  - A duty update takes effect on the next compare; there is no period alignment or glitch guard.
- Reset asserted mid-operation clears everything on that edge; a pending load result is discarded (read_data=0).

Optional Feature:
- Macro: MMIO_PWM_TIMER_CMP_EN.
- When defined:
  - Adds 0x18 MILLIS_CMP (RW, 32-bit, reset 0).
  - Adds 0x1C IRQ_STAT (bit0 sticky flag).
  - Adds output port irq (1 bit, = IRQ_STAT[0]).
  - The flag sets on the clk edge where MILLIS increments to a value equal to MILLIS_CMP.
  - Any store to 0x1C with write_data[0]=1 clears it. If set and clear coincide, set wins.
- When undefined: no irq port exists; offsets 0x18/0x1C behave as unmapped.

Test Plan:
1. Reset low 2 cycles, then high -> read_data=0, hit_q=0, led=red=green=blue=1. LW at 0x10 after 11 clks -> 0; after 12 clks -> 1.
2. SW 0x0000_0080 to 0xFFFF_FF04 -> red low for exactly 128 of every 256 clks. DUTY_R=0 -> red constantly 1. DUTY_R=255 -> red high 1 clk per 256.
3. SW 0xFFFF_FFFF to 0x04, then SB 0x12 to 0x04 -> LW at 0x04 returns 0x0000_0012. LB from 0x00 with LED=1 -> 0x0000_0001. LW from 0x06 (misaligned) -> 0.
4. LB from 0x04 after DUTY_R=0x80 -> 0xFFFF_FF80; LBU -> 0x0000_0080. LW at 0xFFFF_FE00 -> read_data=0, hit_q=0.
5. Run 12,000 clks -> MILLIS=1, MICROS=1000. SW to 0x10 -> MICROS unchanged. Force MICROS to 0xFFFF_FFFF (bench backdoor), one tick -> 0.
6. (MMIO_PWM_TIMER_CMP_EN) MILLIS_CMP=2 -> irq rises on the edge MILLIS becomes 2. Store 1 to 0x1C -> irq=0. Clear on the same edge as a match -> irq stays 1.

Source files
------------

// File: rtl/mmio_pwm_timer.sv
// Memory-mapped LED / RGB PWM / microsecond-millisecond timer peripheral.
// Optional millisecond compare + sticky interrupt when MMIO_PWM_TIMER_CMP_EN is defined.
module mmio_pwm_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
    parameter int          CLK_PER_US     = 12,
    parameter int          US_PER_MS      = 1000,
    parameter int          LED_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        hit_q,
`ifdef MMIO_PWM_TIMER_CMP_EN
    output logic        irq,
`endif
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam logic        INV     = (LED_ACTIVE_LOW != 0);
    localparam logic [15:0] US_LAST = 16'(CLK_PER_US - 1);
    localparam logic [15:0] MS_LAST = 16'(US_PER_MS - 1);

    logic        led_reg;
    logic [7:0]  duty_r, duty_g, duty_b;
    logic [31:0] micros, millis;
    logic [15:0] us_div, ms_div;
    logic [7:0]  pwm_cnt;
    logic        us_wrap, ms_wrap;

    logic        wr_hit;
    logic [5:0]  wr_word;
    logic [3:0]  be;
    logic [31:0] wdata_al;

    logic        rd_hit;
    logic [31:0] rd_word, rd_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

`ifdef MMIO_PWM_TIMER_CMP_EN
    logic [31:0] millis_cmp;
    logic        irq_stat;
    logic        irq_set, irq_clr;
    assign irq = irq_stat;
`else
    logic unused_wr;
    assign unused_wr = ^{be[3:1], wdata_al[31:8]};
`endif

    // Stores become a byte-enable mask plus lane-replicated data; illegal sizes/alignments give an empty mask.
    always_comb begin
        wr_hit   = write_mem && (write_address[31:8] == BASE_ADDR[31:8]);
        wr_word  = write_address[7:2];
        be       = 4'b0000;
        wdata_al = 32'h0;
        if (wr_hit) begin
            case (funct3)
                3'b000: begin
                    be       = 4'b0001 << write_address[1:0];
                    wdata_al = {4{write_data[7:0]}};
                end
                3'b001: if (!write_address[0]) begin
                    be       = write_address[1] ? 4'b1100 : 4'b0011;
                    wdata_al = {2{write_data[15:0]}};
                end
                3'b010: if (write_address[1:0] == 2'b00) begin
                    be       = 4'b1111;
                    wdata_al = write_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_reg <= 1'b0;
            duty_r  <= 8'h00;
            duty_g  <= 8'h00;
            duty_b  <= 8'h00;
        end else if (be[0]) begin
            case (wr_word)
                6'h00:   led_reg <= wdata_al[0];
                6'h01:   duty_r  <= wdata_al[7:0];
                6'h02:   duty_g  <= wdata_al[7:0];
                6'h03:   duty_b  <= wdata_al[7:0];
                default: ;
            endcase
        end
    end

    assign us_wrap = (us_div == US_LAST);
    assign ms_wrap = us_wrap && (ms_div == MS_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            us_div <= 16'h0;
            ms_div <= 16'h0;
            micros <= 32'h0;
            millis <= 32'h0;
        end else if (us_wrap) begin
            us_div <= 16'h0;
            micros <= micros + 32'd1;
            ms_div <= ms_wrap ? 16'h0 : ms_div + 16'd1;
            if (ms_wrap)
                millis <= millis + 32'd1;
        end else begin
            us_div <= us_div + 16'd1;
        end
    end

`ifdef MMIO_PWM_TIMER_CMP_EN
    assign irq_set = ms_wrap && ((millis + 32'd1) == millis_cmp);
    assign irq_clr = be[0] && (wr_word == 6'h07) && wdata_al[0];

    // A match on the same edge as a software clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            millis_cmp <= 32'h0;
            irq_stat   <= 1'b0;
        end else begin
            irq_stat <= irq_set | (irq_stat & ~irq_clr);
            if (wr_word == 6'h06) begin
                for (int i = 0; i < 4; i++)
                    if (be[i])
                        millis_cmp[8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt <= 8'h00;
            red     <= INV;
            green   <= INV;
            blue    <= INV;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            red     <= (pwm_cnt < duty_r) ^ INV;
            green   <= (pwm_cnt < duty_g) ^ INV;
            blue    <= (pwm_cnt < duty_b) ^ INV;
        end
    end

    assign led = led_reg ^ INV;

    // Load path reads pre-store register values, so a same-edge store is not visible yet.
    always_comb begin
        rd_hit = (read_address[31:8] == BASE_ADDR[31:8]);
        case (read_address[7:2])
            6'h00:   rd_word = {31'h0, led_reg};
            6'h01:   rd_word = {24'h0, duty_r};
            6'h02:   rd_word = {24'h0, duty_g};
            6'h03:   rd_word = {24'h0, duty_b};
            6'h04:   rd_word = micros;
            6'h05:   rd_word = millis;
`ifdef MMIO_PWM_TIMER_CMP_EN
            6'h06:   rd_word = millis_cmp;
            6'h07:   rd_word = {31'h0, irq_stat};
`endif
            default: rd_word = 32'h0;
        endcase
        case (read_address[1:0])
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = read_address[1] ? rd_word[31:16] : rd_word[15:0];
        rd_ext  = 32'h0;
        case (funct3)
            3'b000: rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100: rd_ext = {24'h0, rd_byte};
            3'b001: if (!read_address[0]) rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101: if (!read_address[0]) rd_ext = {16'h0, rd_half};
            3'b010: if (read_address[1:0] == 2'b00) rd_ext = rd_word;
            default: ;
        endcase
        if (!rd_hit)
            rd_ext = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data <= 32'h0;
            hit_q     <= 1'b0;
        end else begin
            read_data <= rd_ext;
            hit_q     <= rd_hit;
        end
    end

endmodule
